// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: D = A - B - Bin, with borrow out.
module full_subtractor (
  output logic D,
  output logic Bout,
  input  logic A,
  input  logic B,
  input  logic Bin
);

  always_comb begin
    D    = A ^ B ^ Bin;
    Bout = (~A & B) | (~(A ^ B) & Bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial diff = a - b, LSB first, one bit per clock, valid/ready on both sides.
//
// state  | meaning
// IDLE   | in_ready high, waiting for operands
// RUN    | one bit per cycle through the cell, WIDTH cycles
// DONE   | out_valid high, result held until out_ready
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic             a_msb;
  logic             b_msb;
  logic             cell_d;
  logic             cell_bo;

  full_subtractor u_cell (
    .D    (cell_d),
    .Bout (cell_bo),
    .A    (sa[0]),
    .B    (sb[0]),
    .Bin  (borrow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      sa        <= '0;
      sb        <= '0;
      cnt       <= '0;
      borrow    <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            sa       <= a;
            sb       <= b;
            borrow   <= 1'b0;
            cnt      <= '0;
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          diff   <= {cell_d, diff[WIDTH-1:1]};
          borrow <= cell_bo;
          cnt    <= cnt + 1'b1;
          // the last cell output is the result MSB, so overflow is decided here
          if (cnt == CNT_LAST) begin
            bout      <= cell_bo;
            ovf       <= (a_msb ^ b_msb) & (a_msb ^ cell_d);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH=8 and WIDTH=4.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid8, in_ready8, out_valid8, out_ready8, bout8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       in_valid4, in_ready4, out_valid4, out_ready4, bout4, ovf4;
  logic [3:0] a4, b4, diff4;

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .diff(diff4), .bout(bout4), .ovf(ovf4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!in_ready8 && n < 50) begin
      tick();
      n++;
    end
    check("w8_in_ready_wait", 32'(in_ready8), 32'd1);
    a8 = a; b8 = b; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
  endtask

  // Entered in cycle T+1; result must appear at T+9, then stall with junk on the input.
  task automatic finish8(input string name, input logic [7:0] ed, input logic eb,
                         input logic eo, input int stall);
    int cyc = 1;
    while (!out_valid8 && cyc < 40) begin
      tick();
      cyc++;
    end
    check({name, "_latency"}, 32'(cyc), 32'd9);
    check({name, "_diff"}, 32'(diff8), 32'(ed));
    check({name, "_bout"}, 32'(bout8), 32'(eb));
    check({name, "_ovf"}, 32'(ovf8), 32'(eo));
    for (int i = 0; i < stall; i++) begin
      a8 = 8'hFF; b8 = 8'h00; in_valid8 = 1'b1;
      tick();
      check({name, "_hold"}, {27'd0, diff8, bout8, ovf8, in_ready8, out_valid8} >> 0,
            {27'd0, ed, eb, eo, 1'b0, 1'b1} >> 0);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check({name, "_ov_drop"}, {30'd0, out_valid8, in_ready8}, 32'b01);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input int stall);
    int n = 0;
    int cyc = 1;
    logic [3:0] ed;
    logic eb, eo;
    ed = a - b;
    eb = (a < b);
    eo = (a[3] ^ b[3]) & (a[3] ^ ed[3]);
    while (!in_ready4 && n < 20) begin
      tick();
      n++;
    end
    check("w4_in_ready_wait", 32'(in_ready4), 32'd1);
    a4 = a; b4 = b; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    while (!out_valid4 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("w4_latency", 32'(cyc), 32'd5);
    check("w4_result", {25'd0, diff4, eb ? bout4 : bout4, ovf4, 1'b0} >> 1,
          {25'd0, ed, eb, eo, 1'b0} >> 1);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("w4_hold", {26'd0, diff4, bout4, ovf4}, {26'd0, ed, eb, eo});
    end
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[11];
    int quiet;
    vecs[0]  = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1]  = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2]  = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[3]  = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[4]  = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
    vecs[6]  = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[7]  = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
    vecs[8]  = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b1};
    vecs[9]  = '{8'hC8, 8'hC8, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{8'h64, 8'h32, 8'h32, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) tick();
    check("rst_w8", {27'd0, in_ready8, out_valid8, diff8 != 0, bout8, ovf8}, 32'b10000);
    check("rst_w4", {30'd0, in_ready4, out_valid4}, 32'b10);
    rst_n = 1'b1;
    out_ready8 = 1'b1;
    repeat (2) tick();
    out_ready8 = 1'b0;
    check("out_ready_idle", {30'd0, in_ready8, out_valid8}, 32'b10);

    for (int i = 0; i < 11; i++) begin
      start8(vecs[i].a, vecs[i].b);
      finish8($sformatf("vec%0d", i), vecs[i].d, vecs[i].bo, vecs[i].ov, i % 3);
    end

    // long backpressure with operands offered, then the next op must go through
    start8(8'h12, 8'h05);
    finish8("stall20", 8'h0D, 1'b0, 1'b0, 20);
    start8(8'h64, 8'h32);
    finish8("after_stall", 8'h32, 1'b0, 1'b0, 0);

    // reset in RUN cycle 3: diff already holds partial bits
    start8(8'h33, 8'h11);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_run", {27'd0, in_ready8, out_valid8, diff8 != 0, bout8, ovf8}, 32'b10000);
    repeat (2) tick();
    rst_n = 1'b1;
    quiet = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid8) quiet = 0;
    end
    check("no_valid_after_rst", 32'(quiet), 32'd1);
    start8(8'hAA, 8'h55);
    finish8("post_rst", 8'h55, 1'b0, 1'b1, 0);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        op4(4'(x), 4'(y), int'($urandom_range(0, 3)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
